// File: rtl/tsi_host_arbiter.sv
// Round-robin arbiter that merges N host TSI command streams onto one chip link
// and routes read responses back to the port that issued the read.
module tsi_host_arbiter #(
    parameter int N_PORTS = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_PORTS-1:0]     req_valid,
    output logic [N_PORTS-1:0]     req_ready,
    input  logic [32*N_PORTS-1:0]  req_bits,
    output logic [N_PORTS-1:0]     resp_valid,
    input  logic [N_PORTS-1:0]     resp_ready,
    output logic [31:0]            resp_bits,
    output logic                   tsi_in_valid,
    input  logic                   tsi_in_ready,
    output logic [31:0]            tsi_in_bits,
    input  logic                   tsi_out_valid,
    output logic                   tsi_out_ready,
    input  logic [31:0]            tsi_out_bits,
    output logic                   busy,
    output logic [2:0]             grant_id,
    output logic                   err_cmd,
    output logic                   err_unexp
);

    localparam int MAX_PORTS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  last_grant_q, last_grant_d;
    logic [2:0]  hdr_cnt_q, hdr_cnt_d;
    logic [31:0] cmd_q, cmd_d;
    logic [32:0] data_cnt_q, data_cnt_d;
    logic        err_cmd_q, err_cmd_d;
    logic        err_unexp_q, err_unexp_d;

    // Ports are padded to 8 so the 3-bit grant can index without range issues.
    logic [MAX_PORTS-1:0] valid_pad;
    logic [MAX_PORTS-1:0] resp_ready_pad;
    logic [31:0]          word_pad [MAX_PORTS];

    logic pass_phase;
    logic read_phase;
    logic in_fire;
    logic out_fire;

    generate
        for (genvar gi = 0; gi < MAX_PORTS; gi++) begin : g_pad
            if (gi < N_PORTS) begin : g_port
                assign valid_pad[gi]      = req_valid[gi];
                assign resp_ready_pad[gi] = resp_ready[gi];
                assign word_pad[gi]       = req_bits[32*gi +: 32];
                assign req_ready[gi]      = pass_phase && (grant_q == 3'(gi)) && tsi_in_ready;
                assign resp_valid[gi]     = read_phase && (grant_q == 3'(gi)) && tsi_out_valid;
            end else begin : g_unused
                assign valid_pad[gi]      = 1'b0;
                assign resp_ready_pad[gi] = 1'b0;
                assign word_pad[gi]       = 32'd0;
            end
        end
    endgenerate

    assign pass_phase    = (state_q == HDR) || (state_q == WDATA);
    assign read_phase    = (state_q == RDATA);
    assign tsi_in_valid  = pass_phase && valid_pad[grant_q];
    assign tsi_in_bits   = pass_phase ? word_pad[grant_q] : 32'd0;
    assign in_fire       = tsi_in_valid && tsi_in_ready;
    assign tsi_out_ready = read_phase ? resp_ready_pad[grant_q] : 1'b1;
    assign out_fire      = tsi_out_valid && tsi_out_ready;
    assign resp_bits     = tsi_out_bits;

    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_q;
    assign err_cmd   = err_cmd_q;
    assign err_unexp = err_unexp_q;

    // Round-robin search starting just after the previous owner.
    logic       arb_found;
    logic [2:0] arb_idx;
    logic [2:0] arb_cand;

    always_comb begin
        arb_found = 1'b0;
        arb_idx   = last_grant_q;
        arb_cand  = 3'd0;
        for (int i = 1; i <= MAX_PORTS; i++) begin
            if (i <= N_PORTS) begin
                arb_cand = 3'((int'(last_grant_q) + i) % N_PORTS);
                if (!arb_found && valid_pad[arb_cand]) begin
                    arb_found = 1'b1;
                    arb_idx   = arb_cand;
                end
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        hdr_cnt_d    = hdr_cnt_q;
        cmd_d        = cmd_q;
        data_cnt_d   = data_cnt_q;
        err_cmd_d    = err_cmd_q;
        err_unexp_d  = err_unexp_q;

        if (out_fire && !read_phase) begin
            err_unexp_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                hdr_cnt_d = 3'd0;
                if (arb_found) begin
                    grant_d = arb_idx;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (in_fire) begin
                    hdr_cnt_d = hdr_cnt_q + 3'd1;
                    if (hdr_cnt_q == 3'd0) begin
                        cmd_d = word_pad[grant_q];
                    end
                    if (hdr_cnt_q == 3'd3) begin
                        // 33 bits so len_lo = 0xFFFFFFFF gives 2^32 words.
                        data_cnt_d = {1'b0, word_pad[grant_q]} + 33'd1;
                    end
                    if (hdr_cnt_q == 3'd4) begin
                        if (cmd_q == 32'd1) begin
                            state_d = WDATA;
                        end else if (cmd_q == 32'd0) begin
                            state_d = RDATA;
                        end else begin
                            state_d      = IDLE;
                            err_cmd_d    = 1'b1;
                            last_grant_d = grant_q;
                        end
                    end
                end
            end
            WDATA: begin
                if (in_fire) begin
                    data_cnt_d = data_cnt_q - 33'd1;
                    if (data_cnt_q == 33'd1) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                    end
                end
            end
            RDATA: begin
                if (out_fire) begin
                    data_cnt_d = data_cnt_q - 33'd1;
                    if (data_cnt_q == 33'd1) begin
                        state_d      = IDLE;
                        last_grant_d = grant_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 3'd0;
            last_grant_q <= 3'(N_PORTS - 1);
            hdr_cnt_q    <= 3'd0;
            cmd_q        <= 32'd0;
            data_cnt_q   <= 33'd0;
            err_cmd_q    <= 1'b0;
            err_unexp_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            hdr_cnt_q    <= hdr_cnt_d;
            cmd_q        <= cmd_d;
            data_cnt_q   <= data_cnt_d;
            err_cmd_q    <= err_cmd_d;
            err_unexp_q  <= err_unexp_d;
        end
    end

endmodule

// File: tb/tb_tsi_host_arbiter.sv
// Directed bench for tsi_host_arbiter: packets are fed from per-port word
// queues and the merged stream is compared against hand-built expected lists.
module tb_tsi_host_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [63:0] req_bits = 64'd0;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready = 2'b00;
    logic [31:0] resp_bits;
    logic        tsi_in_valid;
    logic        tsi_in_ready = 1'b1;
    logic [31:0] tsi_in_bits;
    logic        tsi_out_valid = 1'b0;
    logic        tsi_out_ready;
    logic [31:0] tsi_out_bits = 32'd0;
    logic        busy;
    logic [2:0]  grant_id;
    logic        err_cmd;
    logic        err_unexp;

    int total = 0;
    int bad   = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [34:0] obs[$];
    logic [34:0] exp_q[$];
    int first_fire;
    int last_fire;

    tsi_host_arbiter #(.N_PORTS(2)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_bits(req_bits),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_bits(resp_bits),
        .tsi_in_valid(tsi_in_valid), .tsi_in_ready(tsi_in_ready), .tsi_in_bits(tsi_in_bits),
        .tsi_out_valid(tsi_out_valid), .tsi_out_ready(tsi_out_ready), .tsi_out_bits(tsi_out_bits),
        .busy(busy), .grant_id(grant_id), .err_cmd(err_cmd), .err_unexp(err_unexp)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_in_valid"}, 64'(tsi_in_valid), 64'd0);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        chk({tag, "_out_ready"}, 64'(tsi_out_ready), 64'd1);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = 2'b00;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Queue one packet on port p and append it to the expected merged stream.
    task automatic mk_pkt(input int p, input logic [31:0] cmd, input logic [31:0] len,
                          input int ndata, input logic [31:0] tagv);
        logic [31:0] w[$];
        w = {cmd, tagv | 32'h1, tagv | 32'h2, len, 32'd0};
        for (int k = 0; k < ndata; k++) w.push_back(tagv | (32'h100 + 32'(k)));
        foreach (w[i]) begin
            if (p == 0) q0.push_back(w[i]);
            else        q1.push_back(w[i]);
            exp_q.push_back({3'(p), w[i]});
        end
    endtask

    // Drive both ports from their queues until empty; returns at a falling edge.
    task automatic run_ports(input int budget, input bit stall);
        obs.delete();
        first_fire = -1;
        last_fire  = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clock);
            if (q0.size() == 0 && q1.size() == 0) begin
                req_valid    = 2'b00;
                tsi_in_ready = 1'b1;
                return;
            end
            req_valid[0]    = (q0.size() != 0);
            req_valid[1]    = (q1.size() != 0);
            req_bits[31:0]  = (q0.size() != 0) ? q0[0] : 32'd0;
            req_bits[63:32] = (q1.size() != 0) ? q1[0] : 32'd0;
            tsi_in_ready    = stall ? (c % 2 == 0) : 1'b1;
            #1;
            if (tsi_in_valid && tsi_in_ready) begin
                obs.push_back({grant_id, tsi_in_bits});
                if (first_fire < 0) first_fire = c;
                last_fire = c;
            end
            if (req_valid[0] && req_ready[0]) void'(q0.pop_front());
            if (req_valid[1] && req_ready[1]) void'(q1.pop_front());
        end
        chk("run_ports_timeout", 64'd1, 64'd0);
        q0.delete();
        q1.delete();
        req_valid    = 2'b00;
        tsi_in_ready = 1'b1;
    endtask

    task automatic check_obs(input string tag);
        chk({tag, "_count"}, 64'(obs.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
            chk($sformatf("%s_w%0d", tag, i), 64'(obs[i]), 64'(exp_q[i]));
        end
        exp_q.delete();
    endtask

    initial begin
        // Reset state
        do_reset();
        #1;
        chk_idle_outputs("rst");
        chk("rst_grant", 64'(grant_id), 64'd0);
        chk("rst_err_cmd", 64'(err_cmd), 64'd0);
        chk("rst_err_unexp", 64'(err_unexp), 64'd0);

        // Port 0 write, len_lo=3: 9 words back to back
        mk_pkt(0, 32'd1, 32'd3, 4, 32'h1000_0000);
        run_ports(60, 1'b0);
        #1;
        check_obs("wr9");
        chk("wr9_span", 64'(last_fire - first_fire), 64'd8);
        chk("wr9_busy_after", 64'(busy), 64'd0);

        // Both ports valid from reset, two 1-word writes each: 0,1,0,1
        do_reset();
        mk_pkt(0, 32'd1, 32'd0, 1, 32'hA000_0000);
        mk_pkt(1, 32'd1, 32'd0, 1, 32'hB000_0000);
        mk_pkt(0, 32'd1, 32'd0, 1, 32'hA100_0000);
        mk_pkt(1, 32'd1, 32'd0, 1, 32'hB100_0000);
        run_ports(100, 1'b0);
        #1;
        check_obs("rr");
        chk("rr_busy_after", 64'(busy), 64'd0);

        // Port 1 read, len_lo=1
        mk_pkt(1, 32'd0, 32'd1, 0, 32'hC000_0000);
        run_ports(40, 1'b0);
        #1;
        check_obs("rdhdr");
        chk("rd_busy", 64'(busy), 64'd1);
        chk("rd_in_valid", 64'(tsi_in_valid), 64'd0);
        tsi_out_valid = 1'b1;
        tsi_out_bits  = 32'hAAAA0001;
        resp_ready    = 2'b00;
        #1;
        chk("rd_stall_resp_valid", 64'(resp_valid), 64'b10);
        chk("rd_stall_out_ready", 64'(tsi_out_ready), 64'd0);
        @(negedge clock);
        resp_ready = 2'b10;
        #1;
        chk("rd_w0_resp_valid", 64'(resp_valid), 64'b10);
        chk("rd_w0_bits", 64'(resp_bits), 64'hAAAA0001);
        chk("rd_w0_out_ready", 64'(tsi_out_ready), 64'd1);
        @(negedge clock);
        tsi_out_bits = 32'hAAAA0002;
        #1;
        chk("rd_w1_resp_valid", 64'(resp_valid), 64'b10);
        chk("rd_w1_bits", 64'(resp_bits), 64'hAAAA0002);
        @(negedge clock);
        tsi_out_valid = 1'b0;
        resp_ready    = 2'b00;
        #1;
        chk("rd_busy_after", 64'(busy), 64'd0);
        chk("rd_err_unexp", 64'(err_unexp), 64'd0);

        // Write with tsi_in_ready stalling every other cycle
        mk_pkt(0, 32'd1, 32'd1, 2, 32'hD000_0000);
        run_ports(80, 1'b1);
        #1;
        check_obs("stall");
        chk("stall_busy_after", 64'(busy), 64'd0);

        // Illegal command: header forwarded, no data phase, err_cmd set
        mk_pkt(0, 32'd2, 32'd0, 0, 32'hE000_0000);
        run_ports(40, 1'b0);
        #1;
        check_obs("badcmd");
        chk("badcmd_busy", 64'(busy), 64'd0);
        chk("badcmd_err", 64'(err_cmd), 64'd1);

        // Unsolicited response in IDLE
        @(negedge clock);
        tsi_out_valid = 1'b1;
        tsi_out_bits  = 32'h0000DEAD;
        #1;
        chk("unexp_out_ready", 64'(tsi_out_ready), 64'd1);
        chk("unexp_before", 64'(err_unexp), 64'd0);
        @(negedge clock);
        tsi_out_valid = 1'b0;
        #1;
        chk("unexp_set", 64'(err_unexp), 64'd1);
        repeat (3) @(negedge clock);
        #1;
        chk("unexp_held", 64'(err_unexp), 64'd1);

        // Reset after 3rd data word of a 4-word write
        mk_pkt(0, 32'd1, 32'd3, 3, 32'hF000_0000);
        run_ports(40, 1'b0);
        #1;
        check_obs("abort");
        chk("abort_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk_idle_outputs("abort_rst");
        chk("abort_rst_grant", 64'(grant_id), 64'd0);
        chk("abort_rst_err_cmd", 64'(err_cmd), 64'd0);
        chk("abort_rst_err_unexp", 64'(err_unexp), 64'd0);
        mk_pkt(0, 32'd1, 32'd0, 1, 32'h5000_0000);
        run_ports(40, 1'b0);
        #1;
        check_obs("post");
        chk("post_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tsi_host_arbiter.md
TSI_HOST_ARBITER -- requirements
Module: tsi_host_arbiter

Interface
REQ-001 Parameter N_PORTS, default 2: number of host requester ports, range 2..8.
REQ-002 clock  in  1  clock; all state updates on its rising edge.
REQ-003 reset  in  1  reset, synchronous, active-high.
REQ-004 req_valid  in  N_PORTS  per-port TSI command-word valid.
REQ-005 req_ready  out  N_PORTS  per-port command-word accept.
REQ-006 req_bits  in  32*N_PORTS  per-port command word; port p occupies bits [32p+31:32p].
REQ-007 resp_valid  out  N_PORTS  per-port read-response valid.
REQ-008 resp_ready  in  N_PORTS  per-port read-response accept.
REQ-009 resp_bits  out  32  read-response word, shared by all ports.
REQ-010 tsi_in_valid / tsi_in_ready / tsi_in_bits  out / in / out  1/1/32  merged command stream toward the chip.
REQ-011 tsi_out_valid / tsi_out_ready / tsi_out_bits  in / out / in  1/1/32  response stream from the chip.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 grant_id  out  3  index of the current owner port; holds last owner in IDLE.
REQ-014 err_cmd / err_unexp  out  1/1  sticky: illegal command word / unsolicited response word.

Function
REQ-015 Packet format: word0 cmd (0=read, 1=write), word1 addr_lo, word2 addr_hi, word3 len_lo, word4 len_hi, then len_lo+1 data words (write: host->chip; read: chip->host); len_hi is forwarded but ignored for counting.
REQ-016 FSM states: IDLE, HDR, WDATA, RDATA.
REQ-017 IDLE: if any req_valid is high, the grant is the first valid port in round-robin order starting at (last_grant+1) mod N_PORTS; grant_id is registered and the FSM enters HDR next cycle; no word is accepted in IDLE.
REQ-018 HDR/WDATA pass-through, combinational, zero added latency: tsi_in_valid=req_valid[g], tsi_in_bits=req_bits[g], req_ready[g]=tsi_in_ready; req_ready of every other port is 0.
REQ-019 Words are counted only on a tsi_in_valid&tsi_in_ready handshake; stalls on either side hold counters.
REQ-020 HDR: word0 bit-vector is captured as cmd and word3 as len_lo; after the 5th header handshake: cmd==1 -> WDATA, cmd==0 -> RDATA, any other value -> IDLE with err_cmd set.
REQ-021 Data counter is 33 bits, loaded with len_lo+1, so len_lo=0xFFFFFFFF yields 2^32 words without wrap.
REQ-022 WDATA: after the last data-word handshake -> IDLE.
REQ-023 RDATA: resp_valid[g]=tsi_out_valid, resp_bits=tsi_out_bits, tsi_out_ready=resp_ready[g]; all other resp_valid are 0; tsi_in_valid is 0; after the last response handshake -> IDLE.
REQ-024 Only one read is outstanding; no new grant is issued until RDATA completes.
REQ-025 Outside RDATA, tsi_out_ready=1 and any tsi_out_valid word is dropped and sets err_unexp.
REQ-026 last_grant updates to g on return to IDLE; the next arbitration can occur in that IDLE cycle (one bubble cycle minimum between packets).
REQ-027 A requester dropping req_valid mid-packet stalls the link; the grant is never revoked mid-packet.

Reset
REQ-028 On reset: state=IDLE, grant_id=0, last_grant=N_PORTS-1 (so port 0 wins first), counters=0, err_cmd=0, err_unexp=0.
REQ-029 Reset outputs: tsi_in_valid=0, req_ready=0, resp_valid=0, busy=0, tsi_out_ready=1.
REQ-030 Reset asserted mid-packet abandons the packet; the FSM is in IDLE the cycle after reset deasserts, with no partial words re-emitted.

Verification
REQ-031 Port 0 write, len_lo=3, tsi_in_ready=1 -> 9 words appear on tsi_in in order over 9 consecutive cycles, then busy=0.
REQ-032 Ports 0 and 1 both valid from reset, each issuing 1-word writes -> grants alternate 0,1,0,1; no word interleaving between packets.
REQ-033 Port 1 read, len_lo=1; chip returns 0xAAAA0001, 0xAAAA0002 -> resp_valid[1] only, those two words delivered, port 0 receives nothing, then IDLE.
REQ-034 tsi_out_valid=1 with 0xDEAD while IDLE -> word consumed, err_unexp=1 held until reset.
REQ-035 Header cmd=2 -> 5 header words forwarded, err_cmd=1, FSM returns to IDLE with no data phase.
REQ-036 Reset asserted after the 3rd data word of a 4-word write -> all outputs at reset values next cycle; a new port-0 packet is forwarded cleanly.
